bsg_vanilla_remote_load_wb: RTL and testbench

- Downstream consumer of remote load responses (remote_load_resp_s) returning from the manycore network to a vanilla core.
- Buffers responses in a small in-order FIFO.
- Extracts and extends byte/hex/word data per the response load info.
- Presents one writeback request per cycle to either the integer or the FP regfile writeback port, and holds it until that port accepts.

---
 rtl/bsg_vanilla_remote_load_wb.sv | 117 +++++++++++
 tb/tb_bsg_vanilla_remote_load_wb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_vanilla_remote_load_wb.sv
// Remote load response writeback: in-order FIFO feeding the integer / FP regfile writeback ports.
// Optional BSG_VANILLA_RLWB_STALL_CNT_EN adds stall_cnt_o, a saturating count of stalled writeback cycles.
module bsg_vanilla_remote_load_wb #(
  parameter int els_p          = 4,
  parameter int reg_id_width_p = 5,
  parameter int data_width_p   = 32,
  localparam int lg_els_lp     = $clog2(els_p),
  localparam int resp_width_lp = 6 + reg_id_width_p + data_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      resp_v_i,
  input  logic [resp_width_lp-1:0]  resp_i,
  output logic                      resp_ready_o,
  output logic                      int_wb_v_o,
  output logic [reg_id_width_p-1:0] int_wb_rd_o,
  output logic [data_width_p-1:0]   int_wb_data_o,
  input  logic                      int_wb_yumi_i,
  output logic                      fp_wb_v_o,
  output logic [reg_id_width_p-1:0] fp_wb_rd_o,
  output logic [data_width_p-1:0]   fp_wb_data_o,
  input  logic                      fp_wb_yumi_i,
  output logic [lg_els_lp:0]        count_o
`ifdef BSG_VANILLA_RLWB_STALL_CNT_EN
  , output logic [31:0]             stall_cnt_o
`endif
);

  typedef struct packed {
    logic                      float_wb;
    logic [reg_id_width_p-1:0] reg_id;
    logic                      is_unsigned_op;
    logic                      is_byte_op;
    logic                      is_hex_op;
    logic [1:0]                part_sel;
    logic [data_width_p-1:0]   data;
  } resp_s;

  localparam logic [lg_els_lp:0] full_lp = (lg_els_lp + 1)'(els_p);

  logic [resp_width_lp-1:0] mem_r [els_p];
  logic [lg_els_lp-1:0]     rd_ptr_r, wr_ptr_r;
  logic [lg_els_lp:0]       count_r;

  resp_s                    head;
  logic                     nonempty, enq, deq, drop;
  logic [7:0]               byte_sel;
  logic [15:0]              hex_sel;
  logic [data_width_p-1:0]  wb_data;

  assign head         = resp_s'(mem_r[rd_ptr_r]);
  assign nonempty     = (count_r != '0);
  assign resp_ready_o = (count_r != full_lp);
  assign enq          = resp_v_i & resp_ready_o;

  assign fp_wb_v_o  = nonempty & head.float_wb;
  assign int_wb_v_o = nonempty & ~head.float_wb & (head.reg_id != '0);
  assign drop       = nonempty & ~head.float_wb & (head.reg_id == '0);
  assign deq        = (int_wb_v_o & int_wb_yumi_i) | (fp_wb_v_o & fp_wb_yumi_i) | drop;

  always_comb begin
    byte_sel = head.data[{head.part_sel, 3'b000} +: 8];
    hex_sel  = head.data[{head.part_sel[1], 4'b0000} +: 16];
    wb_data  = head.data;
    if (head.is_byte_op)
      wb_data = {{(data_width_p-8){~head.is_unsigned_op & byte_sel[7]}}, byte_sel};
    else if (head.is_hex_op)
      wb_data = {{(data_width_p-16){~head.is_unsigned_op & hex_sel[15]}}, hex_sel};
  end

  // Storage contents are undefined after reset, so the head is masked to zero while empty.
  assign int_wb_rd_o   = nonempty ? head.reg_id : '0;
  assign fp_wb_rd_o    = nonempty ? head.reg_id : '0;
  assign int_wb_data_o = nonempty ? wb_data : '0;
  assign fp_wb_data_o  = nonempty ? wb_data : '0;
  assign count_o       = count_r;

  // NOTE: the data array has no reset; only pointers and count need one, which keeps it RAM-friendly.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= resp_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef BSG_VANILLA_RLWB_STALL_CNT_EN
  logic stall;
  assign stall = (int_wb_v_o & ~int_wb_yumi_i) | (fp_wb_v_o & ~fp_wb_yumi_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                       stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`endif

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(int_wb_yumi_i && !int_wb_v_o)) else $error("int_wb_yumi_i without int_wb_v_o");
      assert (!(fp_wb_yumi_i && !fp_wb_v_o))   else $error("fp_wb_yumi_i without fp_wb_v_o");
      assert (!(enq && resp_i[35] && resp_i[34])) else $error("byte and hex op both set");
    end
  end

endmodule

// File: tb/tb_bsg_vanilla_remote_load_wb.sv
// Self-checking bench for bsg_vanilla_remote_load_wb: vector table plus scoreboard-checked sequences.
module tb_bsg_vanilla_remote_load_wb;

  typedef struct packed {
    logic        float_wb;
    logic [4:0]  reg_id;
    logic        is_unsigned_op;
    logic        is_byte_op;
    logic        is_hex_op;
    logic [1:0]  part_sel;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    resp_t       r;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        resp_v = 1'b0;
  resp_t       resp = '0;
  logic        resp_ready;
  logic        int_v, fp_v, int_yumi, fp_yumi;
  logic [4:0]  int_rd, fp_rd;
  logic [31:0] int_data, fp_data;
  logic [2:0]  count;
  logic        en = 1'b0;
`ifdef BSG_VANILLA_RLWB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int   tests = 0;
  int   fails = 0;
  int   stall_exp = 0;
  exp_t exp_q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  // The bench acts as a regfile that accepts whenever en is set.
  assign int_yumi = int_v & en;
  assign fp_yumi  = fp_v & en;

  bsg_vanilla_remote_load_wb dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .resp_v_i(resp_v), .resp_i(resp), .resp_ready_o(resp_ready),
    .int_wb_v_o(int_v), .int_wb_rd_o(int_rd), .int_wb_data_o(int_data), .int_wb_yumi_i(int_yumi),
    .fp_wb_v_o(fp_v), .fp_wb_rd_o(fp_rd), .fp_wb_data_o(fp_data), .fp_wb_yumi_i(fp_yumi),
    .count_o(count)
`ifdef BSG_VANILLA_RLWB_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic resp_t mk(input logic fp, input logic [4:0] rd, input logic uns,
                               input logic byt, input logic hex, input logic [1:0] ps,
                               input logic [31:0] d);
    resp_t r;
    r = '{float_wb: fp, reg_id: rd, is_unsigned_op: uns, is_byte_op: byt,
          is_hex_op: hex, part_sel: ps, data: d};
    return r;
  endfunction

  function automatic logic [31:0] fmt(input resp_t r);
    logic [31:0] v;
    v = r.data;
    if (r.is_byte_op) begin
      v = (r.data >> (r.part_sel * 8)) & 32'h0000_00FF;
      if (!r.is_unsigned_op && v[7]) v = v | 32'hFFFF_FF00;
    end else if (r.is_hex_op) begin
      v = (r.data >> (r.part_sel[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (!r.is_unsigned_op && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Scoreboard: every accepted writeback is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && !en) stall_exp++;
      if ((int_v && int_yumi) || (fp_v && fp_yumi)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got int_v=%0b fp_v=%0b rd=%0d with no expected writeback",
                   int_v, fp_v, fp_v ? fp_rd : int_rd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb", {int_v, fp_v, fp_v ? fp_rd : int_rd, fp_v ? fp_data : int_data},
                {~e.fp, e.fp, e.rd, e.data});
        end
      end
    end
  end

  // Drives one response, holds it until accepted, then records its expected writeback.
  task automatic send(input resp_t r, input logic [31:0] exp_data);
    bit accepted;
    accepted = 1'b0;
    resp_v = 1'b1;
    resp   = r;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = resp_ready;
      @(posedge clk);
      #1;
    end
    resp_v = 1'b0;
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: response rd=%0d not accepted within 50 cycles", r.reg_id);
    end else if (r.float_wb || r.reg_id != 5'd0) begin
      exp_q.push_back('{fp: r.float_wb, rd: r.reg_id, data: exp_data});
    end
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    @(posedge clk);
    #1;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d writebacks still pending", name, exp_q.size());
    end
    check({name, "_count"}, count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mk(0, 7,  0, 1, 0, 2, 32'h0080_0000), 32'hFFFF_FF80};
    vecs[1] = '{mk(1, 3,  1, 0, 1, 3, 32'hBEEF_1234), 32'h0000_BEEF};
    vecs[2] = '{mk(0, 1,  1, 1, 0, 0, 32'h1234_56F0), 32'h0000_00F0};
    vecs[3] = '{mk(0, 2,  0, 1, 0, 3, 32'h7F00_0000), 32'h0000_007F};
    vecs[4] = '{mk(0, 4,  0, 0, 1, 0, 32'h0001_8000), 32'hFFFF_8000};
    vecs[5] = '{mk(0, 5,  0, 0, 1, 1, 32'hABCD_8001), 32'hFFFF_8001};
    vecs[6] = '{mk(0, 31, 1, 0, 0, 2, 32'hDEAD_BEEF), 32'hDEAD_BEEF};
    vecs[7] = '{mk(1, 0,  0, 0, 0, 0, 32'h3F80_0000), 32'h3F80_0000};
    vecs[8] = '{mk(1, 9,  0, 1, 0, 1, 32'h0000_8100), 32'hFFFF_FF81};
    vecs[9] = '{mk(0, 6,  0, 0, 1, 2, 32'h7FFF_0000), 32'h0000_7FFF};

    // Reset state
    #12;
    check("rst_count", count, 0);
    check("rst_ready", resp_ready, 1);
    check("rst_valids", {int_v, fp_v}, 2'b00);
    check("rst_int_out", {int_rd, int_data}, 0);
    check("rst_fp_out", {fp_rd, fp_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Formatting and routing vectors, streamed with the regfile always accepting
    en = 1'b1;
    for (int i = 0; i < 10; i++) send(vecs[i].r, vecs[i].exp);
    drain("table");

    // Fill to full with the regfile stalled, then release
    en = 1'b0;
    stall_exp = 0;
    for (int i = 1; i <= 4; i++) send(mk(0, 5'(i), 0, 0, 0, 0, 32'hA000_0000 + i), 32'hA000_0000 + i);
    resp_v = 1'b1;
    resp   = mk(0, 5'd5, 0, 0, 0, 0, 32'hA000_0005);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready", resp_ready, 0);
      check("full_count", count, 4);
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    send(mk(0, 5'd5, 0, 0, 0, 0, 32'hA000_0005), 32'hA000_0005);
    drain("fill");
`ifdef BSG_VANILLA_RLWB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_exp);
`endif

    // x0 destination is dropped without a writeback; the next entry follows intact
    send(mk(0, 5'd0, 0, 0, 0, 0, 32'h1111_1111), 32'h1111_1111);
    send(mk(0, 5'd9, 0, 0, 0, 0, 32'h2222_2222), 32'h2222_2222);
    drain("x0");

    // Simultaneous enqueue/dequeue at count 1 across pointer wrap
    for (int i = 0; i < 11; i++) begin
      resp_t r;
      r = mk(i[0], 5'(i + 10), i[1], 1'b0, i[2], 2'(i), 32'h8765_4321 ^ (32'(i) << 13));
      send(r, fmt(r));
      check("stream_count", count, 1);
    end
    drain("stream");

    // Asynchronous reset with three entries buffered
    en = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(0, 5'(20 + i), 0, 0, 0, 0, 32'(i)), 32'(i));
    check("pre_reset_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_valids", {int_v, fp_v}, 2'b00);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1;
    send(mk(1, 5'd12, 0, 0, 1, 2, 32'h9ABC_0000), 32'hFFFF_9ABC);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
